// File: rtl/string_packer.sv
// Byte-stream to packed null-terminated string word builder.
// Characters fill lanes LSB-first; a completed word is held until downstream accepts it.

module string_packer_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= 8'h00;
        else if (we)
            q <= d;
    end
endmodule

module string_packer #(
    parameter int BYTES = 8,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_char,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*BYTES-1:0]   out_string,
    output logic [LEN_W-1:0]     out_length
);
    typedef enum logic {FILL, EMIT} state_t;

    state_t                 state, state_nxt;
    logic [LEN_W-1:0]       count, count_nxt, count_inc, len_nxt;
    logic                   accept, is_null, last, drain;
    logic [BYTES-1:0]       lane_we;
    logic [BYTES-1:0][7:0]  lanes;

    assign accept    = in_valid & in_ready;
    assign is_null   = (in_char == 8'h00);
    assign count_inc = count + LEN_W'(1);
    assign last      = (count_inc == LEN_W'(BYTES));
    assign drain     = (state == EMIT) & out_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state <= FILL;
        else
            state <= state_nxt;
    end

    // A char accepted alongside flush is stored before the word closes.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if ((accept && (is_null || last)) || flush) state_nxt = EMIT;
            EMIT: if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == EMIT);
    end

    always_comb begin
        count_nxt = count;
        len_nxt   = out_length;
        if (drain) begin
            count_nxt = '0;
            len_nxt   = '0;
        end else if (state == FILL) begin
            if (accept && !is_null)
                count_nxt = count_inc;
            if (accept && is_null)
                len_nxt = count;
            else if (accept && (last || flush))
                len_nxt = count_inc;
            else if (flush)
                len_nxt = count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            out_length <= '0;
        end else begin
            count      <= count_nxt;
            out_length <= len_nxt;
        end
    end

    // Null bytes are never written, so unused lanes stay cleared.
    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        assign lane_we[k] = accept & ~is_null & (count == LEN_W'(k));
        string_packer_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (drain),
            .we    (lane_we[k]),
            .d     (in_char),
            .q     (lanes[k])
        );
    end

    assign out_string = lanes;
endmodule
